// File: rtl/mcp_adc_scan_leader.sv
// mcp_adc_scan_leader: SPI leader for MCP300x/MCP320x-class SAR ADCs.
// Scans the channels set in ch_mask in round-robin order, one conversion
// frame per enabled channel. Each result is returned MSB-first assembled and
// tagged with its channel, with a one-cycle valid strobe.
//
// Optional build macro: MCP_PSEUDO_DIFF_EN
//   defined   : adds input diff_mode; when 1 at frame start, the SGL/DIFF
//               bit is driven 0 (pseudo-differential pair select).
//   undefined : single-ended conversions only.
//
// Ports:
//   CLKsample    in   SPI/sample clock, all logic on rising edge
//   RESET        in   asynchronous active-low reset
//   enable       in   1 = scanning permitted
//   ch_mask      in   [NUM_CH]   channel enable mask
//   diff_mode    in   pseudo-differential select (MCP_PSEUDO_DIFF_EN only)
//   Dout         in   ADC serial data out
//   CS           out  ADC chip select, active low
//   Din          out  ADC serial config in
//   Sample_word  out  [RES_BITS] last completed conversion
//   Sample_ch    out  [CH_BITS]  channel of Sample_word
//   Sample_valid out  one-cycle pulse when Sample_word/Sample_ch update
//   busy         out  1 while CS is low
module mcp_adc_scan_leader #(
    parameter int unsigned RES_BITS = 10,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CH_BITS  = 1,
    parameter int unsigned CS_IDLE  = 2
) (
    input  logic                CLKsample,
    input  logic                RESET,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   ch_mask,
`ifdef MCP_PSEUDO_DIFF_EN
    input  logic                diff_mode,
`endif
    input  logic                Dout,
    output logic                CS,
    output logic                Din,
    output logic [RES_BITS-1:0] Sample_word,
    output logic [CH_BITS-1:0]  Sample_ch,
    output logic                Sample_valid,
    output logic                busy
);

    localparam int unsigned CNT_W  = $clog2(RES_BITS + 1);
    localparam int unsigned IDLE_W = $clog2(CS_IDLE + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SGL,
        ST_CHSEL,
        ST_MSBF,
        ST_NULL,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t              state;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [CH_BITS-1:0]  ptr;
    logic [CH_BITS-1:0]  sel;
    logic [CH_BITS-1:0]  chsel_sr;
    logic [CNT_W-1:0]    bit_cnt;
    logic [RES_BITS-1:0] shift_sr;
`ifdef MCP_PSEUDO_DIFF_EN
    logic                diff_sel;
`endif

    logic [NUM_CH-1:0]   rot_mask_c;
    logic [CH_BITS-1:0]  next_ch_c;
    logic                found_c;
    int unsigned         idx_c;
    logic                idle_done_c;

    // Idle counter saturates at CS_IDLE-1, so equality marks "idle time met".
    assign idle_done_c = (idle_cnt == IDLE_W'(CS_IDLE - 1));

    // First set mask bit at or after the pointer, wrapping past NUM_CH-1.
    always_comb begin
        rot_mask_c = NUM_CH'({ch_mask, ch_mask} >> ptr);
        found_c    = 1'b0;
        idx_c      = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!found_c && rot_mask_c[k]) begin
                found_c = 1'b1;
                idx_c   = 32'(ptr) + k;
            end
        end
        if (idx_c >= NUM_CH) begin
            idx_c = idx_c - NUM_CH;
        end
        next_ch_c = CH_BITS'(idx_c);
    end

    // Frame sequencer; Din/CS are set on entry to the state they belong to.
    always_ff @(posedge CLKsample or negedge RESET) begin
        if (!RESET) begin
            state        <= ST_IDLE;
            idle_cnt     <= '0;
            ptr          <= '0;
            sel          <= '0;
            chsel_sr     <= '0;
            bit_cnt      <= '0;
            shift_sr     <= '0;
            CS           <= 1'b1;
            Din          <= 1'b1;
            Sample_word  <= '0;
            Sample_ch    <= '0;
            Sample_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef MCP_PSEUDO_DIFF_EN
            diff_sel     <= 1'b0;
`endif
        end else begin
            Sample_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (idle_done_c && enable && (|ch_mask)) begin
                        state <= ST_START;
                        sel   <= next_ch_c;
                        CS    <= 1'b0;
                        busy  <= 1'b1;
                        Din   <= 1'b1;
`ifdef MCP_PSEUDO_DIFF_EN
                        diff_sel <= diff_mode;
`endif
                    end else if (!idle_done_c) begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                ST_START: begin
                    state <= ST_SGL;
`ifdef MCP_PSEUDO_DIFF_EN
                    Din   <= ~diff_sel;
`else
                    Din   <= 1'b1;
`endif
                end
                ST_SGL: begin
                    state    <= ST_CHSEL;
                    bit_cnt  <= '0;
                    Din      <= sel[CH_BITS-1];
                    chsel_sr <= sel << 1;
                end
                ST_CHSEL: begin
                    if (bit_cnt == CNT_W'(CH_BITS - 1)) begin
                        state <= ST_MSBF;
                        Din   <= 1'b1;
                    end else begin
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                        Din      <= chsel_sr[CH_BITS-1];
                        chsel_sr <= chsel_sr << 1;
                    end
                end
                ST_MSBF: begin
                    state <= ST_NULL;
                    Din   <= 1'b1;
                end
                ST_NULL: begin
                    state   <= ST_DATA;
                    bit_cnt <= '0;
                    Din     <= 1'b1;
                end
                ST_DATA: begin
                    shift_sr <= RES_BITS'({shift_sr, Dout});
                    if (bit_cnt == CNT_W'(RES_BITS - 1)) begin
                        state        <= ST_DONE;
                        CS           <= 1'b1;
                        busy         <= 1'b0;
                        Sample_word  <= RES_BITS'({shift_sr, Dout});
                        Sample_ch    <= sel;
                        Sample_valid <= 1'b1;
                        idle_cnt     <= '0;
                        if (sel == CH_BITS'(NUM_CH - 1)) begin
                            ptr <= '0;
                        end else begin
                            ptr <= sel + CH_BITS'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcp_adc_scan_leader.sv
// Scoreboard bench for mcp_adc_scan_leader: a 2-channel instance (default
// parameters) and an 8-channel/3-bit-select instance, each with its own
// ADC model driving Dout and a monitor popping expected samples on valid.
module tb_mcp_adc_scan_leader;

    localparam int RES   = 10;
    localparam int CHB_A = 1;
    localparam int CHB_B = 3;
    localparam int D0_A  = CHB_A + 4;   // first DATA cycle index within CS-low
    localparam int D0_B  = CHB_B + 4;

    logic       clk = 1'b0;
    logic       RESET;
    logic       en_a, en_b;
    logic [1:0] mask_a;
    logic [7:0] mask_b;
    logic       dout_a, dout_b;
    logic       cs_a, din_a, sv_a, busy_a;
    logic       cs_b, din_b, sv_b, busy_b;
    logic [9:0] word_a, word_b;
    logic [0:0] ch_a;
    logic [2:0] ch_b;

    typedef struct packed {
        logic [2:0] ch;
        logic [9:0] word;
    } exp_t;

    exp_t       qa[$];
    exp_t       qb[$];
    exp_t       ea, eb;
    logic [9:0] wa [0:7];
    logic [9:0] wb [0:7];
    logic [9:0] wtmp_a, wtmp_b;
    logic [2:0] cha, chb;
    int nvec = 0, nerr = 0, cyc = 0;
    int ia = 0, ib = 0, prev_a = -1, prev_b = -1;

    mcp_adc_scan_leader #(.RES_BITS(10), .NUM_CH(2), .CH_BITS(1), .CS_IDLE(2)) u_dut_a (
        .CLKsample(clk), .RESET(RESET), .enable(en_a), .ch_mask(mask_a), .Dout(dout_a),
        .CS(cs_a), .Din(din_a), .Sample_word(word_a), .Sample_ch(ch_a),
        .Sample_valid(sv_a), .busy(busy_a));

    mcp_adc_scan_leader #(.RES_BITS(10), .NUM_CH(8), .CH_BITS(3), .CS_IDLE(2)) u_dut_b (
        .CLKsample(clk), .RESET(RESET), .enable(en_b), .ch_mask(mask_b), .Dout(dout_b),
        .CS(cs_b), .Din(din_b), .Sample_word(word_b), .Sample_ch(ch_b),
        .Sample_valid(sv_b), .busy(busy_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    // ADC model A: checks the command bits and returns wa[channel] MSB-first.
    always @(negedge clk) begin
        if (!RESET) begin
            ia = 0; prev_a = -1; dout_a = 1'b0;
        end else if (!cs_a) begin
            if (ia == 0) begin
                chk("A busy in frame", busy_a, 1);
                chk("A start bit", din_a, 1);
                if (prev_a >= 0) chk("A frame period", cyc - prev_a, 18);
                prev_a = cyc;
                cha = '0;
            end else if (ia == 1) begin
                chk("A sgl bit", din_a, 1);
            end else if (ia < 2 + CHB_A) begin
                cha = {cha[1:0], din_a};
            end else if (ia == 2 + CHB_A) begin
                chk("A msbf bit", din_a, 1);
                if (qa.size() > 0) chk("A chsel bits", cha, qa[0].ch);
            end
            wtmp_a = wa[cha];
            if (ia >= D0_A && ia < D0_A + RES) dout_a = wtmp_a[RES-1-(ia-D0_A)];
            else dout_a = 1'b0;
            ia++;
        end else begin
            if (ia != 0) begin
                chk("A cs low length", ia, 15);
                chk("A busy after frame", busy_a, 0);
                ia = 0;
            end
            dout_a = 1'b0;
            if (!en_a || mask_a == 2'b00) prev_a = -1;
        end
    end

    // ADC model B (8 channels, 3 select bits).
    always @(negedge clk) begin
        if (!RESET) begin
            ib = 0; prev_b = -1; dout_b = 1'b0;
        end else if (!cs_b) begin
            if (ib == 0) begin
                chk("B busy in frame", busy_b, 1);
                chk("B start bit", din_b, 1);
                if (prev_b >= 0) chk("B frame period", cyc - prev_b, 20);
                prev_b = cyc;
                chb = '0;
            end else if (ib == 1) begin
                chk("B sgl bit", din_b, 1);
            end else if (ib < 2 + CHB_B) begin
                chb = {chb[1:0], din_b};
            end else if (ib == 2 + CHB_B) begin
                chk("B msbf bit", din_b, 1);
                if (qb.size() > 0) chk("B chsel bits", chb, qb[0].ch);
            end
            wtmp_b = wb[chb];
            if (ib >= D0_B && ib < D0_B + RES) dout_b = wtmp_b[RES-1-(ib-D0_B)];
            else dout_b = 1'b0;
            ib++;
        end else begin
            if (ib != 0) begin
                chk("B cs low length", ib, 17);
                chk("B busy after frame", busy_b, 0);
                ib = 0;
            end
            dout_b = 1'b0;
            if (!en_b || mask_b == 8'h00) prev_b = -1;
        end
    end

    // Monitors: pop expected sample on every valid strobe.
    always @(negedge clk) begin
        if (RESET && sv_a) begin
            if (qa.size() == 0) chk("A unexpected valid", 1, 0);
            else begin
                ea = qa.pop_front();
                chk("A sample_ch", ch_a, ea.ch);
                chk("A sample_word", word_a, ea.word);
                chk("A cs high at valid", cs_a, 1);
            end
        end
        if (RESET && sv_b) begin
            if (qb.size() == 0) chk("B unexpected valid", 1, 0);
            else begin
                eb = qb.pop_front();
                chk("B sample_ch", ch_b, eb.ch);
                chk("B sample_word", word_b, eb.word);
            end
        end
    end

    task automatic push_a(input logic [2:0] ch, input logic [9:0] w);
        exp_t e;
        e.ch = ch; e.word = w;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [2:0] ch, input logic [9:0] w);
        exp_t e;
        e.ch = ch; e.word = w;
        qb.push_back(e);
    endtask

    task automatic drain_a(input int maxc);
        int n = 0;
        while (qa.size() != 0 && n < maxc) begin
            @(negedge clk); #1; n++;
        end
        chk("A scoreboard drained", qa.size(), 0);
        qa.delete();
    endtask

    task automatic drain_b(input int maxc);
        int n = 0;
        while (qb.size() != 0 && n < maxc) begin
            @(negedge clk); #1; n++;
        end
        chk("B scoreboard drained", qb.size(), 0);
        qb.delete();
    endtask

    task automatic wait_ia(input int tgt, input int maxc);
        int n = 0;
        while (ia != tgt && n < maxc) begin
            @(negedge clk); #1; n++;
        end
        chk("A reached frame cycle", ia, tgt);
    endtask

    task automatic quiet_a(input int ncyc, input string nm);
        int lo = 0, vl = 0;
        repeat (ncyc) begin
            @(negedge clk); #1;
            if (!cs_a) lo++;
            if (sv_a) vl++;
        end
        chk({nm, " cs low cycles"}, lo, 0);
        chk({nm, " valid pulses"}, vl, 0);
    endtask

    initial begin
        RESET = 1'b0; en_a = 1'b0; en_b = 1'b0; mask_a = '0; mask_b = '0;
        for (int i = 0; i < 8; i++) begin
            wa[i] = '0; wb[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("reset CS", cs_a, 1);
        chk("reset Din", din_a, 1);
        chk("reset Sample_word", word_a, 0);
        chk("reset Sample_ch", ch_a, 0);
        chk("reset Sample_valid", sv_a, 0);
        chk("reset busy", busy_a, 0);
        chk("reset B CS", cs_b, 1);
        chk("reset B Sample_word", word_b, 0);

        // 1: single channel 0, three back-to-back frames
        wa[0] = 10'h2A5; mask_a = 2'b01; en_a = 1'b1;
        repeat (3) push_a(3'd0, 10'h2A5);
        @(negedge clk); RESET = 1'b1;
        drain_a(200); en_a = 1'b0;

        // 2: both channels; pointer resumes at 1 after channel 0
        wa[0] = 10'h155; wa[1] = 10'h3FF; mask_a = 2'b11;
        push_a(3'd1, 10'h3FF); push_a(3'd0, 10'h155);
        push_a(3'd1, 10'h3FF); push_a(3'd0, 10'h155);
        en_a = 1'b1;
        drain_a(300); en_a = 1'b0;

        // 3: empty mask holds idle, then channel 1 only
        mask_a = 2'b00; en_a = 1'b1;
        quiet_a(50, "empty mask");
        push_a(3'd1, 10'h3FF);
        mask_a = 2'b10;
        drain_a(100); en_a = 1'b0;

        // 4: enable dropped in DATA; frame still completes, then idle
        wa[0] = 10'h0F0; mask_a = 2'b01;
        push_a(3'd0, 10'h0F0);
        en_a = 1'b1;
        wait_ia(D0_A + 3, 100);
        en_a = 1'b0;
        drain_a(100);
        quiet_a(30, "enable off");

        // 5: reset mid-DATA of a channel-1 frame; restart from channel 0
        mask_a = 2'b11; en_a = 1'b1;
        wait_ia(D0_A + 4, 100);
        RESET = 1'b0;
        #1;
        chk("async reset CS", cs_a, 1);
        chk("async reset busy", busy_a, 0);
        chk("async reset Sample_word", word_a, 0);
        chk("async reset Sample_valid", sv_a, 0);
        wa[0] = 10'h1C3;
        push_a(3'd0, 10'h1C3);
        @(negedge clk); @(negedge clk);
        RESET = 1'b1;
        drain_a(100); en_a = 1'b0;

        // 6: 8-channel instance, channels 0 and 7
        wb[0] = 10'h123; wb[7] = 10'h2DC; mask_b = 8'b1000_0001;
        push_b(3'd0, 10'h123); push_b(3'd7, 10'h2DC); push_b(3'd0, 10'h123);
        en_b = 1'b1;
        drain_b(200); en_b = 1'b0;

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

endmodule
